// File: rtl/dwt_multilevel_sched.sv
// Multi-level in-place Haar DWT sequencer driving one shared pair core.
// For each pair it reads two samples, holds them on the core for CORE_LAT cycles,
// writes cA back in place and emits cD on a ready/valid detail stream.
// Optional build macro DWT_STALL_CNT_EN adds the stall_cnt output, which counts
// the cycles the consumer held off a valid detail coefficient.
module dwt_multilevel_sched #(
  parameter int unsigned N        = 8,
  parameter int unsigned CORE_LAT = 2,
  parameter int unsigned AW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    levels_cfg,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic [15:0]   core_x0,
  output logic [15:0]   core_x1,
  input  logic [15:0]   core_cA,
  input  logic [15:0]   core_cD,
  output logic          det_valid,
  input  logic          det_ready,
  output logic [15:0]   det_data,
  output logic [3:0]    det_level,
`ifdef DWT_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic [AW-1:0] det_idx
);

  localparam int unsigned DW       = 16;
  localparam logic [3:0]  MAX_LVL  = 4'(AW);
  localparam logic [3:0]  LAT_LAST = 4'(CORE_LAT - 1);
  localparam logic [AW-1:0] HALF_N = AW'(N / 2);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_CAP0, S_CAP1, S_WAIT, S_WR, S_DHOLD, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   k_q, k_d, half_q, half_d;
  logic [3:0]      level_q, level_d, cfg_q, cfg_d, wait_q, wait_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            rd_en_q, rd_en_d, wr_en_q, wr_en_d, dv_q, dv_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, di_q, di_d;
  logic [DW-1:0]   wr_data_q, wr_data_d, x0_q, x0_d, x1_q, x1_d, dd_q, dd_d;
  logic [3:0]      dl_q, dl_d;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    half_d    = half_q;
    level_d   = level_q;
    cfg_d     = cfg_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    dv_d      = 1'b0;
    dd_d      = dd_q;
    dl_d      = dl_q;
    di_d      = di_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((levels_cfg == 4'd0) || (levels_cfg > MAX_LVL)) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_RD0;
            k_d     = '0;
            half_d  = HALF_N;
            level_d = 4'd1;
            cfg_d   = levels_cfg;
          end
        end
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        state_d = S_CAP0;
        x0_d    = rd_data;
      end
      S_CAP0: begin
        state_d = S_CAP1;
        x1_d    = rd_data;
      end
      S_CAP1: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == LAT_LAST) begin
          state_d   = S_WR;
          wr_en_d   = 1'b1;
          wr_addr_d = k_q;
          wr_data_d = core_cA;
          dv_d      = 1'b1;
          dd_d      = core_cD;
          dl_d      = level_q;
          di_d      = k_q;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_WR, S_DHOLD: begin
        if (!det_ready) begin
          state_d = S_DHOLD;
          dv_d    = 1'b1;
        end else if (k_q != (half_q - AW'(1))) begin
          k_d     = k_q + AW'(1);
          state_d = S_RD0;
        end else if (level_q == cfg_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          level_d = level_q + 4'd1;
          half_d  = half_q >> 1;
          k_d     = '0;
          state_d = S_RD0;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    rd_en_d   = (state_d == S_RD0) || (state_d == S_RD1);
    rd_addr_d = rd_addr_q;
    if (rd_en_d) begin
      rd_addr_d = AW'({k_d, (state_d == S_RD1)});
    end
  end

  // State, counters and registered outputs; reset abandons any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      half_q    <= '0;
      level_q   <= '0;
      cfg_q     <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      dv_q      <= 1'b0;
      dd_q      <= '0;
      dl_q      <= '0;
      di_q      <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      half_q    <= half_d;
      level_q   <= level_d;
      cfg_q     <= cfg_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      dv_q      <= dv_d;
      dd_q      <= dd_d;
      dl_q      <= dl_d;
      di_q      <= di_d;
    end
  end

`ifdef DWT_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles a valid detail waited on the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (dv_q && !det_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_x0   = x0_q;
  assign core_x1   = x1_q;
  assign det_valid = dv_q;
  assign det_data  = dd_q;
  assign det_level = dl_q;
  assign det_idx   = di_q;

endmodule

// File: tb/tb_dwt_multilevel_sched.sv
// Bench for dwt_multilevel_sched: N=8 buffer, pipelined Haar core model
// (cA=x0+x1, cD=x0-x1), plus two small instances with CORE_LAT 1 and 5.
module tb_dwt_multilevel_sched;

  localparam int LAT = 2;

  typedef struct packed {
    logic [3:0]  lvl;
    logic [2:0]  idx;
    logic [15:0] d;
  } det_t;

  logic        clk, rst_n, start, det_ready;
  logic [3:0]  levels_cfg;
  logic        busy, done, err, rd_en, wr_en, det_valid;
  logic [2:0]  rd_addr, wr_addr, det_idx;
  logic [15:0] rd_data, wr_data, core_x0, core_x1, core_cA, core_cD, det_data;
  logic [3:0]  det_level;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0, stall_seen = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int hs_base = 0, st_base = 0;
  int rdy_mode = 0;
  logic ld, lld, lstart;

  logic [15:0] mem [8];
  logic [15:0] init_buf [8];
  logic [15:0] exp_buf [8];
  logic [15:0] pa [LAT];
  logic [15:0] pd [LAT];
  det_t expq [$];
  int exp_pairs;

  dwt_multilevel_sched #(.N(8), .CORE_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .levels_cfg(levels_cfg),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_x0(core_x0), .core_x1(core_x1), .core_cA(core_cA), .core_cD(core_cD),
    .det_valid(det_valid), .det_ready(det_ready), .det_data(det_data),
    .det_level(det_level),
`ifdef DWT_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .det_idx(det_idx)
  );
`ifndef DWT_STALL_CNT_EN
  assign stall_cnt = 16'd0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous buffer RAM and LAT-stage pair core.
  always @(posedge clk) begin
    if (ld) for (int i = 0; i < 8; i++) mem[i] <= init_buf[i];
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
    pa[0] <= core_x0 + core_x1;
    pd[0] <= core_x0 - core_x1;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign core_cA = pa[LAT-1];
  assign core_cD = pd[LAT-1];

  // Latency variants: levels_cfg=1, always ready.
  for (genvar g = 0; g < 2; g++) begin : lat_g
    localparam int CL = (g == 0) ? 1 : 5;
    logic        busy_l, done_l, err_l, rd_en_l, wr_en_l, dv_l;
    logic [2:0]  rd_addr_l, wr_addr_l, di_l;
    logic [15:0] rd_data_l, wr_data_l, x0_l, x1_l, dd_l;
    logic [3:0]  dl_l;
    logic [15:0] sc_l;
    logic [15:0] mem [8];
    logic [15:0] qa [CL];
    logic [15:0] qd [CL];
    int cyc_l, wcnt;
    int wt [4];
    logic dseen;

    always @(posedge clk) begin
      qa[0] <= x0_l + x1_l;
      qd[0] <= x0_l - x1_l;
      for (int i = 1; i < CL; i++) begin
        qa[i] <= qa[i-1];
        qd[i] <= qd[i-1];
      end
      if (lld) begin
        for (int i = 0; i < 8; i++) mem[i] <= 16'(i + 1);
        wcnt  <= 0;
        cyc_l <= 0;
        dseen <= 1'b0;
      end else begin
        cyc_l <= cyc_l + 1;
        if (wr_en_l) begin
          mem[wr_addr_l] <= wr_data_l;
          if (wcnt < 4) wt[wcnt] <= cyc_l;
          wcnt <= wcnt + 1;
        end
        if (done_l) dseen <= 1'b1;
      end
      if (rd_en_l) rd_data_l <= mem[rd_addr_l];
    end

    dwt_multilevel_sched #(.N(8), .CORE_LAT(CL)) u_lat (
      .clk(clk), .rst_n(rst_n), .start(lstart), .levels_cfg(4'd1),
      .busy(busy_l), .done(done_l), .err(err_l),
      .rd_en(rd_en_l), .rd_addr(rd_addr_l), .rd_data(rd_data_l),
      .wr_en(wr_en_l), .wr_addr(wr_addr_l), .wr_data(wr_data_l),
      .core_x0(x0_l), .core_x1(x1_l), .core_cA(qa[CL-1]), .core_cD(qd[CL-1]),
      .det_valid(dv_l), .det_ready(1'b1), .det_data(dd_l), .det_level(dl_l),
`ifdef DWT_STALL_CNT_EN
      .stall_cnt(sc_l),
`endif
      .det_idx(di_l)
    );
`ifndef DWT_STALL_CNT_EN
    assign sc_l = 16'd0;
`endif
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Consumer ready: 0 always ready, 1 random, 2 stall 10 cycles on the second detail.
  initial begin
    det_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       det_ready = 1'b1;
        1:       det_ready = ($urandom_range(0, 2) != 0);
        default: det_ready = !(((hs_cnt - hs_base) == 1) && ((stall_seen - st_base) < 10));
      endcase
    end
  end

  // Per-cycle checker against the expected detail stream and stream rules.
  initial begin
    logic        prev_hold;
    logic [15:0] pdd;
    logic [3:0]  pdl;
    logic [2:0]  pdi;
    det_t        e;
    prev_hold = 1'b0;
    pdd = '0; pdl = '0; pdi = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          chk("det_stable", {det_valid, det_level, det_idx, det_data}, {1'b1, pdl, pdi, pdd});
        if (det_valid && det_ready) begin
          hs_cnt++;
          if (expq.size() == 0) begin
            chk("det_extra", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("det_beat", {det_level, det_idx, det_data}, e);
          end
        end
        if (det_valid && !det_ready) stall_seen++;
        if (!busy) chk("idle_quiet", {rd_en, wr_en, det_valid}, 0);
        if (wr_en) wr_cnt++;
        if (rd_en) rd_cnt++;
        if (done) done_cnt++;
        prev_hold = det_valid && !det_ready;
        pdd = det_data; pdl = det_level; pdi = det_idx;
      end
    end
  end

  // Reference: whole-transform arithmetic over the buffer, level by level.
  task automatic build_model(input int lv);
    logic [15:0] b [8];
    det_t e;
    for (int i = 0; i < 8; i++) b[i] = init_buf[i];
    expq.delete();
    exp_pairs = 0;
    for (int l = 1; l <= lv; l++) begin
      for (int k = 0; k < (8 >> l); k++) begin
        e.lvl = 4'(l);
        e.idx = 3'(k);
        e.d   = b[2*k] - b[2*k+1];
        expq.push_back(e);
        b[k] = b[2*k] + b[2*k+1];
        exp_pairs++;
      end
    end
    for (int i = 0; i < 8; i++) exp_buf[i] = b[i];
  endtask

  task automatic load_buf();
    @(posedge clk); #1 ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
  endtask

  task automatic do_run(input logic [3:0] lv, input bit bstart, input bit exp_err,
                        output int cyc, output int stalls);
    int wr0, rd0, dn0;
    bit busy_ok, seen;
    logic err_at;
    build_model(exp_err ? 0 : int'(lv));
    load_buf();
    hs_base = hs_cnt; st_base = stall_seen;
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; levels_cfg = lv;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; seen = 0; busy_ok = 1; err_at = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        err_at = err;
      end else begin
        if (!busy) busy_ok = 0;
        cyc++;
        start = bstart && ((cyc % 5) == 2) && (cyc < 40);
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    stalls = stall_seen - st_base;
    chk("done_seen", seen, 1);
    chk("run_cycles", cyc, exp_err ? 0 : exp_pairs * (5 + LAT) + stalls);
    chk("err_flag", err_at, exp_err);
    if (!exp_err) chk("busy_during_run", busy_ok, 1);
    chk("writes", wr_cnt - wr0, exp_pairs);
    chk("reads", rd_cnt - rd0, 2 * exp_pairs);
    chk("done_count", done_cnt - dn0, 1);
    chk("det_left", expq.size(), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("buf[%0d]", i), mem[i], exp_buf[i]);
  endtask

  task automatic chk_lat(input string nm, input int cl, input int w0, input int w1,
                         input int w2, input int w3, input logic [63:0] m);
    chk({nm, "_spacing"}, (w1 - w0 == 5 + cl) && (w2 - w1 == 5 + cl) && (w3 - w2 == 5 + cl), 1);
    chk({nm, "_first_gap"}, w1 - w0, 5 + cl);
    chk({nm, "_cA"}, m, {16'd3, 16'd7, 16'd11, 16'd15});
  endtask

  initial begin
    int cyc, st, n;
    logic [22:0] lit [7];
    rst_n = 1'b0; start = 1'b0; levels_cfg = 4'd0;
    ld = 1'b0; lld = 1'b0; lstart = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", |{busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, core_x0,
                        core_x1, det_valid, det_data, det_level, det_idx}, 0);
    rst_n = 1'b1;

    // Pin the model on the hand-computed 1..8 case.
    for (int i = 0; i < 8; i++) init_buf[i] = 16'(i + 1);
    build_model(3);
    lit = '{{4'd1, 3'd0, 16'hFFFF}, {4'd1, 3'd1, 16'hFFFF}, {4'd1, 3'd2, 16'hFFFF},
            {4'd1, 3'd3, 16'hFFFF}, {4'd2, 3'd0, 16'hFFFC}, {4'd2, 3'd1, 16'hFFFC},
            {4'd3, 3'd0, 16'hFFF0}};
    chk("model_len", expq.size(), 7);
    for (int i = 0; i < 7; i++) chk("model_beat", expq[i], lit[i]);
    chk("model_buf0", exp_buf[0], 36);

    // Directed 1..8, three levels, always ready.
    rdy_mode = 0;
    do_run(4'd3, 0, 0, cyc, st);
    chk("directed_cycles", cyc, 49);
    chk("directed_buf0", mem[0], 36);

    // Invalid depths.
    do_run(4'd0, 0, 1, cyc, st);
    do_run(4'd4, 0, 1, cyc, st);

    // Consumer stall of 10 cycles on the second detail.
    rdy_mode = 2;
    do_run(4'd3, 0, 0, cyc, st);
    chk("stall_cycles", cyc, 59);
    chk("stall_seen", st, 10);
`ifdef DWT_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 10);
`endif
    rdy_mode = 0;

    // Start pulses while busy are ignored.
    do_run(4'd3, 1, 0, cyc, st);
    chk("busy_start_cycles", cyc, 49);
    n = done_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("no_extra_done", done_cnt - n, 0);
    chk("idle_after", busy, 0);

    // Reset during the first level-2 WAIT abandons the run.
    build_model(3);
    load_buf();
    hs_base = hs_cnt;
    @(posedge clk); #1 start = 1'b1; levels_cfg = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while ((hs_cnt - hs_base) < 4 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_level2", hs_cnt - hs_base, 4);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", |{busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, core_x0,
                              core_x1, det_valid, det_data, det_level, det_idx}, 0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || rd_en || wr_en || det_valid) n++;
    end
    chk("quiet_in_reset", n, 0);
    rst_n = 1'b1;
    expq.delete();
    n = done_cnt;
    repeat (5) @(negedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - n, 0);
    for (int i = 0; i < 8; i++) init_buf[i] = 16'($urandom);
    do_run(4'd3, 0, 0, cyc, st);

    // Random data, depth and backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) init_buf[i] = 16'($urandom);
      do_run(4'($urandom_range(1, 3)), 0, 0, cyc, st);
`ifdef DWT_STALL_CNT_EN
      chk("stall_cnt_rand", stall_cnt, st);
`endif
    end
    rdy_mode = 0;

    // Core latency 1 and 5 with one level.
    @(posedge clk); #1 lld = 1'b1;
    @(posedge clk); #1 lld = 1'b0; lstart = 1'b1;
    @(posedge clk); #1 lstart = 1'b0;
    n = 0;
    while (!(lat_g[0].dseen && lat_g[1].dseen) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("lat_done", lat_g[0].dseen && lat_g[1].dseen, 1);
    chk_lat("lat1", 1, lat_g[0].wt[0], lat_g[0].wt[1], lat_g[0].wt[2], lat_g[0].wt[3],
            {lat_g[0].mem[0], lat_g[0].mem[1], lat_g[0].mem[2], lat_g[0].mem[3]});
    chk_lat("lat5", 5, lat_g[1].wt[0], lat_g[1].wt[1], lat_g[1].wt[2], lat_g[1].wt[3],
            {lat_g[1].mem[0], lat_g[1].mem[1], lat_g[1].mem[2], lat_g[1].mem[3]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
